fifo_reader: RTL and testbench

Read-side controller that drains an 8-bit synchronous FIFO and presents its words on a valid/ready stream. It issues FIFO read enables, absorbs the FIFO's one-cycle read latency, and buffers up to two words so a continuously ready consumer gets one word per clock. It sits between the FIFO's read port (`en_read`/`data_out`) and any downstream consumer, such as a serializer or packet builder.

---
 rtl/fifo_reader_pkg.sv | 11 +
 rtl/fifo_reader_skid.sv | 73 +++++++
 rtl/fifo_reader.sv | 80 ++++++++
 tb/tb_fifo_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader read-side controller.
package fifo_reader_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int BUF_DEPTH      = 2;
endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: captures FIFO words at the tail, presents the head
// on registered m_data/m_valid. Optional m_parity with FIFO_READER_PARITY_EN.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic [1:0]        occ
`ifdef FIFO_READER_PARITY_EN
    ,
    output logic              m_parity
`endif
);
    logic [DATA_W-1:0] mem     [BUF_DEPTH];
    logic [DATA_W-1:0] mem_nxt [BUF_DEPTH];
    logic              head, tail, head_nxt, tail_nxt;
    logic [1:0]        occ_nxt;
    logic              pop;

    assign pop = m_valid && m_ready;

    // With occ==2 a push only happens alongside a pop, so overwriting the
    // slot being popped is safe.
    always_comb begin
        mem_nxt  = mem;
        head_nxt = head;
        tail_nxt = tail;
        occ_nxt  = occ;
        if (push) begin
            mem_nxt[tail] = push_data;
            tail_nxt      = ~tail;
        end
        if (pop)
            head_nxt = ~head;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            occ     <= 2'd0;
            m_data  <= '0;
            m_valid <= 1'b0;
`ifdef FIFO_READER_PARITY_EN
            m_parity <= 1'b0;
`endif
        end else begin
            mem     <= mem_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            occ     <= occ_nxt;
            m_data  <= mem_nxt[head_nxt];
            m_valid <= (occ_nxt != 2'd0);
`ifdef FIFO_READER_PARITY_EN
            m_parity <= ^mem_nxt[head_nxt];
`endif
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// Read-side controller draining a synchronous FIFO onto a valid/ready stream.
// Optional m_parity output enabled by FIFO_READER_PARITY_EN.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy
`ifdef FIFO_READER_PARITY_EN
    ,
    output logic              m_parity
`endif
);
    state_t     state;
    logic       inflight;
    logic [1:0] occ;
    logic [1:0] level;
    logic       pop;

    assign pop   = m_valid && m_ready;
    assign level = occ + {1'b0, inflight};

    // Count the in-flight word as occupied so the buffer can never overflow.
    assign fifo_rd_en = (state == RUN) && !fifo_empty &&
                        ((level < 2'd2) || ((level == 2'd2) && pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            case (state)
                IDLE: if (drain_en) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!drain_en)
                    state <= DRAIN;
                DRAIN: begin
                    if (drain_en)
                        state <= RUN;
                    else if (!inflight && occ == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    fifo_reader_skid #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data(fifo_rd_data),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .occ      (occ)
`ifdef FIFO_READER_PARITY_EN
        ,
        .m_parity (m_parity)
`endif
    );
endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural one-cycle-latency FIFO.
module tb_fifo_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drain_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
`ifdef FIFO_READER_PARITY_EN
    logic       m_parity;
`endif

    always #5 clk = ~clk;

    fifo_reader #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .drain_en    (drain_en),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy)
`ifdef FIFO_READER_PARITY_EN
        ,
        .m_parity    (m_parity)
`endif
    );

    logic [7:0] fifo_mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       empty_force = 1'b0;

    assign fifo_empty = empty_force || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end else
            fifo_rd_data <= 8'h00;
    end

    logic [7:0] got_mem [256];
    int         got_cnt = 0;
    int         rd_cnt  = 0;
    int         empty_viol = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_mem[got_cnt[7:0]] = m_data;
            got_cnt = got_cnt + 1;
        end
        if (fifo_rd_en)
            rd_cnt = rd_cnt + 1;
        if (fifo_rd_en && fifo_empty)
            empty_viol = empty_viol + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int g0, r0;
        #12;
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_data", {24'd0, m_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        reset = 1'b0;

        // Burst of four with consumer always ready.
        tick();
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        m_ready = 1'b1;
        drain_en = 1'b1;
        #1 chk("t1_idle_no_rd", {31'd0, fifo_rd_en}, 0);
        tick();
        chk("t1_first_rd", {31'd0, fifo_rd_en}, 1);
        chk("t1_busy", {31'd0, busy}, 1);
        tick();
        chk("t1_valid_early", {31'd0, m_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t1_valid%0d", i), {31'd0, m_valid}, 1);
            chk($sformatf("t1_data%0d", i), {24'd0, m_data}, 32'h11 + i);
        end
        tick();
        chk("t1_valid_end", {31'd0, m_valid}, 0);
        chk("t1_busy_hold", {31'd0, busy}, 1);
        drain_en = 1'b0;
        wait_idle("t1_idle");

        // Consumer stalled for six cycles.
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        m_ready = 1'b0;
        g0 = got_cnt;
        r0 = rd_cnt;
        drain_en = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_hold%0d", i), {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h11});
        end
        chk("t2_reads_stalled", rd_cnt - r0, 2);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t2_count", got_cnt - g0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_order%0d", i), {24'd0, got_mem[(g0 + i) % 256]}, 32'h11 + i);
        drain_en = 1'b0;
        wait_idle("t2_idle");

        // drain_en dropped in the same cycle as the only read.
        push_word(8'hA5);
        m_ready = 1'b1;
        drain_en = 1'b1;
        tick();
        chk("t4_rd", {31'd0, fifo_rd_en}, 1);
        drain_en = 1'b0;
        tick();
        chk("t4_no_rd", {31'd0, fifo_rd_en}, 0);
        chk("t4_busy_drain", {31'd0, busy}, 1);
        tick();
        chk("t4_data", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'hA5});
        tick();
        chk("t4_popped", {31'd0, m_valid}, 0);
        chk("t4_busy_last", {31'd0, busy}, 1);
        tick();
        chk("t4_idle", {31'd0, busy}, 0);

        // fifo_empty toggling every cycle, random consumer.
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        g0 = got_cnt;
        empty_viol = 0;
        drain_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            empty_force = ~empty_force;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        empty_force = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_empty_viol", empty_viol, 0);
        chk("t3_count", got_cnt - g0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_order%0d", i), {24'd0, got_mem[(g0 + i) % 256]}, 32'h30 + i);
        drain_en = 1'b0;
        wait_idle("t3_idle");

        // Asynchronous reset in the middle of a stalled burst.
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        m_ready = 1'b0;
        drain_en = 1'b1;
        tick(); tick(); tick();
        chk("t5_pre_valid", {31'd0, m_valid}, 1);
        #3 reset = 1'b1;
        #1;
        chk("t5_valid", {31'd0, m_valid}, 0);
        chk("t5_data", {24'd0, m_data}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_rd_en", {31'd0, fifo_rd_en}, 0);
        drain_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t5_no_rd_idle", {31'd0, fifo_rd_en}, 0);
        drain_en = 1'b1;
        #1 chk("t5_no_rd_first", {31'd0, fifo_rd_en}, 0);
        tick();
        chk("t5_rd_after", {31'd0, fifo_rd_en}, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        drain_en = 1'b0;
        wait_idle("t5_idle");
        wr_ptr = rd_ptr;

`ifdef FIFO_READER_PARITY_EN
        begin
            logic [7:0] pw [4];
            logic       pe [4];
            pw[0] = 8'h00; pw[1] = 8'h01; pw[2] = 8'hFF; pw[3] = 8'h7F;
            pe[0] = 1'b0;  pe[1] = 1'b1;  pe[2] = 1'b0;  pe[3] = 1'b1;
            for (int i = 0; i < 4; i++) push_word(pw[i]);
            m_ready = 1'b1;
            drain_en = 1'b1;
            tick(); tick();
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("par_data%0d", i), {24'd0, m_data}, {24'd0, pw[i]});
                chk($sformatf("par%0d", i), {31'd0, m_parity}, {31'd0, pe[i]});
            end
            drain_en = 1'b0;
            wait_idle("par_idle");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
